// File: rtl/ov_1101_pkg.sv
// rtl/ov_1101_pkg.sv - state encodings and pattern constant for the 1101 detector
package ov_1101_pkg;

    localparam int STATE_W = 3;

    typedef logic [STATE_W-1:0] state_t;

    localparam state_t S0   = 3'd0;
    localparam state_t S1   = 3'd1;
    localparam state_t S11  = 3'd2;
    localparam state_t S110 = 3'd3;
    localparam state_t DET  = 3'd4;

    localparam logic [3:0] PATTERN = 4'b1101;

endpackage

// File: rtl/ov_1101_det_if.sv
// rtl/ov_1101_det_if.sv - serial bit in / match flag out bundle; match_cnt only with OV_1101_CNT_EN
interface ov_1101_det_if #(
    parameter int CNT_W = 8
);

    logic in;
    logic out;

    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("ov_1101_det_if: CNT_W must be at least 1");
    end

`ifdef OV_1101_CNT_EN
    logic [CNT_W-1:0] match_cnt;

    modport master (output in, input out, input match_cnt);
    modport slave  (input in, output out, output match_cnt);
`else
    modport master (output in, input out);
    modport slave  (input in, output out);
`endif

endinterface

// File: rtl/ov_1101_cnt.sv
// rtl/ov_1101_cnt.sv - wrapping match counter, instantiated only with OV_1101_CNT_EN
module ov_1101_cnt #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/ov_1101_det.sv
// rtl/ov_1101_det.sv - overlapping Moore detector for 1101; OV_1101_CNT_EN adds match_cnt
module ov_1101_det
    import ov_1101_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic          clk,
    input  logic          rst,
    ov_1101_det_if.slave  bus
);

    state_t state;
    state_t state_d;

    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("ov_1101_det: CNT_W must be at least 1");
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S0;
        end else begin
            state <= state_d;
        end
    end

    // After DET the trailing 1 plus a new 1 already forms the "11" prefix.
    always_comb begin
        state_d = S0;
        case (state)
            S0:      state_d = (bus.in == PATTERN[3]) ? S1   : S0;
            S1:      state_d = (bus.in == PATTERN[2]) ? S11  : S0;
            S11:     state_d = (bus.in == PATTERN[1]) ? S110 : S11;
            S110:    state_d = (bus.in == PATTERN[0]) ? DET  : S0;
            DET:     state_d = bus.in ? S11 : S0;
            default: state_d = S0;
        endcase
    end

    assign bus.out = (state == DET);

`ifdef OV_1101_CNT_EN
    ov_1101_cnt #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc_i (state_d == DET),
        .cnt_o (bus.match_cnt)
    );
`endif

endmodule

// File: tb/tb_ov_1101_det.sv
// tb/tb_ov_1101_det.sv - directed bench for ov_1101_det; counter checks with OV_1101_CNT_EN
module tb_ov_1101_det;

    logic clk = 1'b0;
    logic rst;

    ov_1101_det_if #(.CNT_W(8)) bus ();

    ov_1101_det #(
        .CNT_W (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

`ifdef OV_1101_CNT_EN
    ov_1101_det_if #(.CNT_W(2)) bus2 ();

    assign bus2.in = bus.in;

    ov_1101_det #(
        .CNT_W (2)
    ) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2.slave)
    );
`endif

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic step(input logic b, input int exp_st, input logic exp_out, input string tag);
        @(negedge clk);
        bus.in = b;
        @(posedge clk);
        #1;
        chk({tag, " state"}, 32'(dut.state), 32'(exp_st));
        chk({tag, " out"}, 32'(bus.out), 32'(exp_out));
    endtask

    task automatic drive(input logic b);
        @(negedge clk);
        bus.in = b;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_rst(input string tag);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk({tag, " rst state"}, 32'(dut.state), 32'd0);
        chk({tag, " rst out"}, 32'(bus.out), 32'd0);
        #1 rst = 1'b0;
    endtask

    logic ov_in [10] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    int   ov_st [10] = '{0, 1, 2, 2, 3, 4, 2, 3, 4, 0};
    logic ov_out[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

    logic rp_in [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    int   rp_st [7] = '{1, 2, 2, 2, 2, 3, 4};
    logic rp_out[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    logic nm_in [7] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    int   nm_st [7] = '{1, 0, 1, 2, 3, 0, 1};

    initial begin
        rst    = 1'b1;
        bus.in = 1'b0;

        #2;
        chk("reset t2 state", 32'(dut.state), 32'd0);
        chk("reset t2 out", 32'(bus.out), 32'd0);
        @(posedge clk); #1;
        chk("reset edge1 state", 32'(dut.state), 32'd0);
        chk("reset edge1 out", 32'(bus.out), 32'd0);
        @(posedge clk); #1;
        chk("reset edge2 state", 32'(dut.state), 32'd0);
        chk("reset edge2 out", 32'(bus.out), 32'd0);
        @(negedge clk);
        bus.in = 1'b1;
        rst    = 1'b0;
        @(posedge clk); #1;
        chk("post-reset in=1 state", 32'(dut.state), 32'd1);
        chk("post-reset in=1 out", 32'(bus.out), 32'd0);

        pulse_rst("overlap");
        for (int i = 0; i < 10; i++) begin
            step(ov_in[i], ov_st[i], ov_out[i], $sformatf("overlap bit%0d", i + 1));
        end

        for (int i = 0; i < 7; i++) begin
            step(rp_in[i], rp_st[i], rp_out[i], $sformatf("ones bit%0d", i + 1));
        end

        step(1'b0, 0, 1'b0, "det then 0");
        for (int i = 0; i < 7; i++) begin
            step(nm_in[i], nm_st[i], 1'b0, $sformatf("nearmiss bit%0d", i + 1));
        end

        step(1'b0, 0, 1'b0, "midmatch clear");
        step(1'b1, 1, 1'b0, "midmatch 1");
        step(1'b1, 2, 1'b0, "midmatch 11");
        step(1'b0, 3, 1'b0, "midmatch 110");
        pulse_rst("midmatch");
        step(1'b1, 1, 1'b0, "midmatch after rst");

`ifdef OV_1101_CNT_EN
        pulse_rst("count");
        chk("count cleared", 32'(bus.match_cnt), 32'd0);
        chk("count2 cleared", 32'(bus2.match_cnt), 32'd0);
        begin
            logic [9:0] s1;
            logic [5:0] s2;
            s1 = 10'b1101101101;
            s2 = 6'b101101;
            for (int i = 9; i >= 0; i--) drive(s1[i]);
            chk("count three", 32'(bus.match_cnt), 32'd3);
            for (int i = 5; i >= 0; i--) drive(s2[i]);
            chk("count five", 32'(bus.match_cnt), 32'd5);
            chk("count2 wrap", 32'(bus2.match_cnt), 32'd1);
        end
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
